// File: rtl/rf_scoreboard_if.sv
// Issue, writeback and status signals between decode and the register-hazard scoreboard.
// The master side is decode/writeback; the slave side is the scoreboard.
interface rf_scoreboard_if;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic        issue_rs1_used;
  logic [4:0]  issue_rs2;
  logic        issue_rs2_used;
  logic [4:0]  issue_rd;
  logic        issue_rd_wr;
  logic        issue_ready;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic        flush;
  logic [31:0] busy_vec;
  logic        err_underflow;

  modport master (
    output issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
    output issue_rd, issue_rd_wr, wb_en, wb_reg, flush,
    input  issue_ready, busy_vec, err_underflow
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
    input  issue_rd, issue_rd_wr, wb_en, wb_reg, flush,
    output issue_ready, busy_vec, err_underflow
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Register-hazard scoreboard: per-register pending-write counters that stall issue
// on RAW hazards and on WAW depth overflow; x0 is never tracked.
module rf_scoreboard #(
  parameter  int MAX_PENDING = 3,
  localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input logic            clk,
  input logic            rst_n,
  rf_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PENDING);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r     [32];
  logic [CNT_W-1:0] cnt_nxt_s [32];
  logic [31:0]      busy_s;
  logic [31:0]      full_s;
  logic [31:0]      inc_s;
  logic [31:0]      dec_s;
  logic             hazard_s;
  logic             ready_s;
  logic             fire_s;
  logic             uf_s;
  logic             err_r;

  // Busy/full decode of the registered counts and the resulting issue stall.
  always_comb begin
    busy_s = 32'd0;
    full_s = 32'd0;
    for (int r = 1; r < 32; r++) begin
      busy_s[r] = (cnt_r[r] != CNT_ZERO);
      full_s[r] = (cnt_r[r] == CNT_MAX);
    end
    // Entry 0 of busy_s/full_s is always 0, which makes x0 operands hazard-free.
    hazard_s = (sb.issue_rs1_used && busy_s[sb.issue_rs1]) ||
               (sb.issue_rs2_used && busy_s[sb.issue_rs2]) ||
               (sb.issue_rd_wr    && full_s[sb.issue_rd])  ||
               sb.flush;
    if (!rst_n) begin
      ready_s = 1'b0;
    end else begin
      ready_s = !hazard_s;
    end
    fire_s = sb.issue_valid && ready_s;
  end

  // Next count per register; flush overrides, and a same-cycle fire and writeback cancel.
  always_comb begin
    inc_s = 32'd0;
    dec_s = 32'd0;
    uf_s  = 1'b0;
    for (int r = 0; r < 32; r++) begin
      cnt_nxt_s[r] = cnt_r[r];
      inc_s[r] = (r != 0) && fire_s && sb.issue_rd_wr && (sb.issue_rd == 5'(r));
      dec_s[r] = (r != 0) && sb.wb_en && (sb.wb_reg == 5'(r));
      if (r == 0) begin
        cnt_nxt_s[r] = CNT_ZERO;
      end else if (sb.flush) begin
        cnt_nxt_s[r] = CNT_ZERO;
      end else if (inc_s[r] && !dec_s[r]) begin
        if (cnt_r[r] != CNT_MAX) begin
          cnt_nxt_s[r] = cnt_r[r] + CNT_ONE;
        end else begin
          cnt_nxt_s[r] = cnt_r[r];
        end
      end else if (dec_s[r] && !inc_s[r]) begin
        if (cnt_r[r] == CNT_ZERO) begin
          cnt_nxt_s[r] = CNT_ZERO;
          uf_s         = 1'b1;
        end else begin
          cnt_nxt_s[r] = cnt_r[r] - CNT_ONE;
        end
      end else begin
        cnt_nxt_s[r] = cnt_r[r];
      end
    end
  end

  // Counter and sticky underflow flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        cnt_r[r] <= CNT_ZERO;
      end
      err_r <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_r[r] <= cnt_nxt_s[r];
      end
      if (uf_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign sb.issue_ready   = ready_s;
  assign sb.busy_vec      = busy_s;
  assign sb.err_underflow = err_r;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rf_scoreboard;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests;
  int   fails;

  typedef struct {
    int          cyc;
    string       name;
    logic        rdy;
    logic [31:0] busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  rf_scoreboard_if sb_if ();

  rf_scoreboard #(.MAX_PENDING(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation stamped for the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      tests = tests + 1;
      if (mon_e.cyc != cyc || sb_if.issue_ready !== mon_e.rdy ||
          sb_if.busy_vec !== mon_e.busy || sb_if.err_underflow !== mon_e.err) begin
        fails = fails + 1;
        $display("FAIL %s (cyc %0d): got ready=%0b busy=%h err=%0b, expected ready=%0b busy=%h err=%0b",
                 mon_e.name, cyc, sb_if.issue_ready, sb_if.busy_vec, sb_if.err_underflow,
                 mon_e.rdy, mon_e.busy, mon_e.err);
      end
    end
  end

  task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic w, input logic wbe, input logic [4:0] wbr, input logic fl);
    sb_if.issue_valid    = v;
    sb_if.issue_rs1      = rs1;
    sb_if.issue_rs1_used = u1;
    sb_if.issue_rs2      = rs2;
    sb_if.issue_rs2_used = u2;
    sb_if.issue_rd       = rd;
    sb_if.issue_rd_wr    = w;
    sb_if.wb_en          = wbe;
    sb_if.wb_reg         = wbr;
    sb_if.flush          = fl;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic chk(input string n, input logic r, input logic [31:0] b, input logic e);
    exp_t x;
    x.cyc  = cyc;
    x.name = n;
    x.rdy  = r;
    x.busy = b;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    idle();
    tick();
    // 1: reset and idle
    chk("reset", 1'b0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b1;
    drv(1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("idle_ready", 1'b1, 32'h0, 1'b0);
    tick();
    // 2: RAW on x5
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("fire_x5", 1'b1, 32'h0, 1'b0);
    tick();
    drv(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("raw_rs1", 1'b0, 32'h0000_0020, 1'b0);
    tick();
    drv(1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("raw_rs2", 1'b0, 32'h0000_0020, 1'b0);
    tick();
    drv(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd5, 1'b0);
    chk("no_wb_bypass", 1'b0, 32'h0000_0020, 1'b0);
    tick();
    drv(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("raw_cleared", 1'b1, 32'h0, 1'b0);
    tick();
    // 3: x0 never tracked
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("x0_fire", 1'b1, 32'h0, 1'b0);
    tick();
    drv(1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
    chk("x0_after_fire", 1'b1, 32'h0, 1'b0);
    tick();
    idle();
    chk("x0_wb_no_uf", 1'b1, 32'h0, 1'b0);
    tick();
    // 4: WAW saturation on x9
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
      chk("waw_fill", 1'b1, (i == 0) ? 32'h0 : 32'h0000_0200, 1'b0);
      tick();
    end
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("waw_full", 1'b0, 32'h0000_0200, 1'b0);
    tick();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0);
    chk("waw_full_wb_cycle", 1'b0, 32'h0000_0200, 1'b0);
    tick();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("waw_room", 1'b1, 32'h0000_0200, 1'b0);
    tick();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
    chk("waw_drain2", 1'b1, 32'h0000_0200, 1'b0);
    tick();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
    chk("waw_drain1", 1'b1, 32'h0000_0200, 1'b0);
    tick();
    // 5: same-cycle fire+wb on x3, then underflow on x4
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("x9_empty", 1'b1, 32'h0, 1'b0);
    tick();
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0);
    chk("fire_wb_x3", 1'b1, 32'h0000_0008, 1'b0);
    tick();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
    chk("x3_net_zero", 1'b1, 32'h0000_0008, 1'b0);
    tick();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
    chk("x3_drained", 1'b1, 32'h0, 1'b0);
    tick();
    idle();
    chk("underflow_set", 1'b1, 32'h0, 1'b1);
    tick();
    chk("underflow_sticky", 1'b1, 32'h0, 1'b1);
    tick();
    // 6: flush, then asynchronous reset
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
      chk("flush_fill", 1'b1, (i == 0) ? 32'h0 : 32'h0000_0020, 1'b1);
      tick();
    end
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b1);
    chk("flush_cycle", 1'b0, 32'h0000_0020, 1'b1);
    tick();
    idle();
    chk("flush_cleared", 1'b1, 32'h0, 1'b1);
    tick();
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("fire_x10", 1'b1, 32'h0, 1'b1);
    tick();
    drv(1'b0, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("pre_reset", 1'b0, 32'h0000_0400, 1'b1);
    tick();
    rst_n = 1'b0;
    chk("async_reset", 1'b0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b1;
    drv(1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("post_reset", 1'b1, 32'h0, 1'b0);
    tick();
    tick();
    tests = tests + 1;
    if (exp_q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
